pckys_game: RTL and testbench

Single-player reaction game packaged as a TinyTapeout user tile. An LFSR lights one of eight target LEDs on `uio_out` and the player must press the matching button on `ui_in` before a round timer expires. Hits increment a score shown as a hex digit on the 7-segment display on `uo_out`; misses cost a life, and losing all lives ends the game.

---
 rtl/pckys_game_pkg.sv | 35 +++
 rtl/pckys_game_hex_to_7seg.sv | 14 +
 rtl/pckys_game.sv | 197 +++++++++++++++++++
 tb/tb_pckys_game.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pckys_game_pkg.sv
// rtl/pckys_game_pkg.sv - shared types and constants for the pckys_game reaction game
//
// Purpose: game state encoding, 7-segment glyph table and LFSR constants.
// Ports:   none (package).
package pckys_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_PLAY = 3'd2,
    ST_HIT  = 3'd3,
    ST_MISS = 3'd4,
    ST_OVER = 3'd5
  } state_e;

  // Right-shift Galois mask for x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  // Glyphs for 0..F, bit0 = segment a; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    logic [7:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pckys_game_hex_to_7seg.sv
// rtl/pckys_game_hex_to_7seg.sv - hex digit to 7-segment decoder
//
// Purpose: combinational lookup of the glyph for a 4-bit value.
// Ports:   hex_i [3:0] digit in; seg_o [6:0] segments a..g (bit0 = a), active-high.
module hex_to_7seg
  import pckys_game_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/pckys_game.sv
// rtl/pckys_game.sv - single-player reaction game TinyTapeout tile
//
// Purpose: an LFSR lights one of eight target LEDs; the player must press the
//          matching button before the round timer expires. Hits raise a score
//          shown on the 7-segment display, misses cost lives.
// Ports:   clk      system clock
//          rst_n    reset, asynchronous, ACTIVE-HIGH despite its name
//          ena      tile select (ignored)
//          ui_in    [7:0] player buttons, active-high, asynchronous
//          uio_in   [7:0] unused
//          uo_out   [7:0] [6:0] score segments, [7] status dot
//          uio_out  [7:0] target LEDs
//          uio_oe   [7:0] constant 8'hFF
// Config:  PCKYS_GAME_SPEEDUP_EN - when defined, round length shrinks as
//          ROUND_CYCLES >> score[3:2].
module pckys_game
  import pckys_game_pkg::*;
#(
  parameter int unsigned ROUND_CYCLES = 1024,
  parameter int unsigned LIVES        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [15:0] ROUND_LEN  = ROUND_CYCLES[15:0];
  localparam logic [2:0]  LIVES_INIT = LIVES[2:0];

  logic unused_inputs;
  assign unused_inputs = ^{ena, uio_in};

  // Input path: two-flop synchroniser plus previous-value register for edges.
  logic [7:0] sync1_q, sync2_q, prev_q;
  logic [7:0] press;
  logic       held;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= ui_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign press = sync2_q & ~prev_q;
  assign held  = (sync2_q != 8'h00);

  // Free-running LFSR; the target is taken from whatever value it holds
  // when the player lets go, which is what makes the lane unpredictable.
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  // Game state.
  state_e      state_q, state_d;
  logic [3:0]  score_q, score_d;
  logic [2:0]  lives_q, lives_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  target_q, target_d;
  logic        dp_q, dp_d;

  logic [15:0] round_len;
  logic [15:0] timer_load;

`ifdef PCKYS_GAME_SPEEDUP_EN
  assign round_len = ROUND_LEN >> score_q[3:2];
`else
  assign round_len = ROUND_LEN;
`endif

  // A shifted-down length can reach zero for tiny ROUND_CYCLES; treat it as
  // a one-cycle round instead of letting the timer wrap.
  assign timer_load = (round_len == 16'd0) ? 16'd0 : (round_len - 16'd1);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      score_q  <= 4'd0;
      lives_q  <= LIVES_INIT;
      timer_q  <= 16'd0;
      target_q <= 8'h00;
      dp_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      timer_q  <= timer_d;
      target_q <= target_d;
      dp_q     <= dp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    lives_d  = lives_q;
    timer_d  = timer_q;
    target_d = target_q;
    dp_d     = dp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (press != 8'h00) begin
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        // Holding any button keeps us here so a stale press cannot score.
        if (!held) begin
          target_d = 8'h01 << lfsr_q[2:0];
          timer_d  = timer_load;
          state_d  = ST_PLAY;
        end
      end

      ST_PLAY: begin
        // A press wins over expiry, so a target press in the last cycle hits.
        if (press != 8'h00) begin
          if ((press & ~target_q) == 8'h00) begin
            state_d = ST_HIT;
          end else begin
            state_d = ST_MISS;
          end
        end else if (timer_q == 16'd0) begin
          state_d = ST_MISS;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      ST_HIT: begin
        if (score_q != 4'hF) begin
          score_d = score_q + 4'd1;
        end
        dp_d    = 1'b1;
        state_d = ST_ARM;
      end

      ST_MISS: begin
        lives_d = lives_q - 3'd1;
        dp_d    = 1'b0;
        state_d = (lives_q == 3'd1) ? ST_OVER : ST_ARM;
      end

      ST_OVER: begin
        if (press != 8'h00) begin
          score_d = 4'd0;
          lives_d = LIVES_INIT;
          dp_d    = 1'b0;
          state_d = ST_ARM;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decodes of registered state only.
  logic [6:0] seg;

  hex_to_7seg u_hex_to_7seg (
    .hex_i (score_q),
    .seg_o (seg)
  );

  always_comb begin
    uio_out = 8'h00;
    if (state_q == ST_PLAY) begin
      uio_out = target_q;
    end else if (state_q == ST_OVER) begin
      uio_out = 8'hFF;
    end
  end

  assign uo_out = {dp_q | (state_q == ST_OVER), seg};
  assign uio_oe = 8'hFF;

endmodule

// File: tb/tb_pckys_game.sv
// tb/tb_pckys_game.sv - directed self-checking bench for pckys_game
module tb_pckys_game;

  localparam int RC = 16;
  localparam int LV = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena   = 1'b1;
  logic [7:0] ui_in  = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  always #5 clk = ~clk;

  pckys_game #(.ROUND_CYCLES(RC), .LIVES(LV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int         score = 0;
  logic       dp    = 1'b0;
  logic [7:0] tgt   = 8'h00;
  int         waited;
  logic [6:0] seg_tb [16];

  // Reference LFSR; m_prev is the value held before the most recent edge.
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_lfsr <= 8'h01;
      m_prev <= 8'h01;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] uo_exp();
    return {dp, seg_tb[score]};
  endfunction

  // Called at a negedge with no target lit; waits for PLAY entry.
  task automatic wait_play(input string tag);
    waited = 0;
    while (uio_out == 8'h00 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    tgt = 8'd1 << m_prev[2:0];
    chk(tag, uio_out, tgt);
  endtask

  task automatic do_hit(input string tag);
    ui_in = tgt;
    repeat (4) @(negedge clk);
    if (score < 15) score++;
    dp = 1'b1;
    chk(tag, uo_out, uo_exp());
    ui_in = 8'h00;
    wait_play({tag, "_next"});
    chk({tag, "_arm_lat"}, 8'(waited), 8'd3);
  endtask

  task automatic do_press_miss(input string tag, input logic [7:0] v);
    ui_in = v;
    repeat (4) @(negedge clk);
    dp = 1'b0;
    chk(tag, uo_out, uo_exp());
    ui_in = 8'h00;
    wait_play({tag, "_next"});
  endtask

  task automatic do_timeout(input string tag, input int len, input bit last);
    repeat (len - 1) @(negedge clk);
    chk({tag, "_lit"}, uio_out, tgt);
    @(negedge clk);
    chk({tag, "_miss"}, uio_out, 8'h00);
    dp = 1'b0;
    @(negedge clk);
    if (last) begin
      chk({tag, "_over_led"}, uio_out, 8'hFF);
      chk({tag, "_over_uo"}, uo_out, {1'b1, seg_tb[score]});
    end else begin
      wait_play({tag, "_next"});
    end
  endtask

  task automatic do_restart(input string tag);
    ui_in = 8'h00;
    repeat (3) @(negedge clk);
    ui_in = 8'h10;
    repeat (3) @(negedge clk);
    score = 0;
    dp    = 1'b0;
    chk({tag, "_uo"}, uo_out, 8'h3F);
    chk({tag, "_led"}, uio_out, 8'h00);
    ui_in = 8'h00;
    wait_play({tag, "_next"});
  endtask

  initial begin
    seg_tb = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_uo", uo_out, 8'h3F);
    chk("rst_led", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'hFF);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_uo", uo_out, 8'h3F);
    chk("idle_led", uio_out, 8'h00);

    // Start: ARM holds while the button is down.
    ui_in = 8'h01;
    repeat (6) @(negedge clk);
    chk("arm_hold", uio_out, 8'h00);
    ui_in = 8'h00;
    wait_play("first_play");
    chk("first_arm_lat", 8'(waited), 8'd3);

    do_hit("hit1");
    chk("hit1_seg", uo_out, 8'h86);
    do_press_miss("wrong_lane", {tgt[6:0], tgt[7]});
    do_timeout("tmo1", RC, 1'b0);

    // Press seen in the very last cycle still hits.
    repeat (13) @(negedge clk);
    ui_in = tgt;
    repeat (4) @(negedge clk);
    score++;
    dp = 1'b1;
    chk("last_cycle_hit", uo_out, uo_exp());
    ui_in = 8'h00;
    wait_play("last_cycle_next");

    // One cycle too late: miss, last life gone.
    repeat (14) @(negedge clk);
    ui_in = tgt;
    repeat (3) @(negedge clk);
    dp = 1'b0;
    chk("late_over_led", uio_out, 8'hFF);
    chk("late_over_uo", uo_out, {1'b1, seg_tb[score]});

    do_restart("restart1");
    do_timeout("tmo_a", RC, 1'b0);
    do_timeout("tmo_b", RC, 1'b0);
    do_timeout("tmo_c", RC, 1'b1);

    do_restart("restart2");
    do_hit("hit_r2");
    do_press_miss("combo_miss", tgt | {tgt[0], tgt[7:1]});

`ifdef PCKYS_GAME_SPEEDUP_EN
    for (int i = 0; i < 3; i++) do_hit("speed_hit");
    chk("speed_score4", uo_out, 8'hE6);
    do_timeout("speed_tmo", RC / 2, 1'b0);
`else
    for (int i = 0; i < 15; i++) do_hit("sat_hit");
    chk("sat_seg", {1'b0, uo_out[6:0]}, 8'h71);
`endif

    // Reset mid-round aborts immediately.
    ui_in = tgt;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_led", uio_out, 8'h00);
    chk("midrst_uo", uo_out, 8'h3F);
    ui_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("postrst_idle", uio_out, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
